// File: rtl/mm_result_unpack.sv
// mm_result_unpack
// Unpacks the matrix-multiply result stream. Each input word carries LANES
// accumulator results; they are emitted one per beat, sign-extended to OUT_W
// and tagged with their row/column position in the M x N2 result frame.
// Frame length is checked against s_tlast and any mismatch raises a sticky
// framing error.
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   packed result stream in
//   m_tdata/m_tvalid/m_tready/m_tlast   one sign-extended result per beat out
//   m_row, m_col  row/column index of the result on m_tdata
//   frame_done    one-cycle pulse after the final result of a frame is taken
//   frame_err     sticky framing error (cleared only by rst)
module mm_result_unpack #(
   parameter int M       = 8,
   parameter int N2      = 4,
   parameter int D_W_ACC = 16,
   parameter int IN_W    = 32,
   parameter int OUT_W   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [IN_W-1:0]       s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   output logic [OUT_W-1:0]      m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast,
   output logic [$clog2(M)-1:0]  m_row,
   output logic [$clog2(N2)-1:0] m_col,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int LANES   = IN_W / D_W_ACC;
   localparam int RESULTS = M * N2;
   localparam int WORDS   = RESULTS / LANES;
   localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int WCNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int ROW_W   = $clog2(M);
   localparam int COL_W   = $clog2(N2);

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    hold_q, hold_d;
   logic               holdLast_q, holdLast_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               frameDone_q, frameDone_d;
   logic               frameErr_q, frameErr_d;

   logic               lastLane;
   logic               inHs;
   logic               outHs;
   logic [D_W_ACC-1:0] laneData;

   // Output view of the held word. The final lane is the one whose handshake
   // frees the holding register, which is why s_tready can open in the same
   // cycle and keep the stream running without a bubble between words.
   assign lastLane   = (lane_q == LANE_W'(LANES - 1));
   assign laneData   = hold_q[int'(lane_q) * D_W_ACC +: D_W_ACC];
   assign m_tvalid   = (state_q == HOLD);
   assign m_tdata    = (state_q == HOLD) ? OUT_W'($signed(laneData)) : '0;
   assign m_tlast    = (state_q == HOLD) & holdLast_q & lastLane;
   assign m_row      = row_q;
   assign m_col      = col_q;
   assign frame_done = frameDone_q;
   assign frame_err  = frameErr_q;
   assign s_tready   = (state_q == EMPTY) | ((state_q == HOLD) & lastLane & m_tready);
   assign inHs       = s_tvalid & s_tready;
   assign outHs      = m_tvalid & m_tready;

   // Next-state logic: word holding / lane stepping, word counter with
   // length checking, and the row/column index counters.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      holdLast_d  = holdLast_q;
      lane_d      = lane_q;
      wcnt_d      = wcnt_q;
      row_d       = row_q;
      col_d       = col_q;
      frameDone_d = 1'b0;
      frameErr_d  = frameErr_q;

      case (state_q)
         EMPTY: begin
            if (s_tvalid) begin
               hold_d     = s_tdata;
               holdLast_d = s_tlast;
               lane_d     = '0;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (m_tready) begin
               if (!lastLane) begin
                  lane_d = lane_q + 1'b1;
               end else if (s_tvalid) begin
                  hold_d     = s_tdata;
                  holdLast_d = s_tlast;
                  lane_d     = '0;
               end else begin
                  state_d = EMPTY;
               end
            end
         end
         default: state_d = EMPTY;
      endcase

      // An early tlast and a missing tlast are both framing errors; either
      // way the word counter restarts so the next frame is counted afresh.
      if (inHs) begin
         if (s_tlast) begin
            if (wcnt_q != WCNT_W'(WORDS - 1)) begin
               frameErr_d = 1'b1;
            end
            wcnt_d = '0;
         end else if (wcnt_q == WCNT_W'(WORDS - 1)) begin
            frameErr_d = 1'b1;
            wcnt_d     = '0;
         end else begin
            wcnt_d = wcnt_q + 1'b1;
         end
      end

      // m_tlast always resynchronises the indices; running off the end of
      // the frame without it wraps the indices and flags an error.
      if (outHs) begin
         if (m_tlast) begin
            row_d       = '0;
            col_d       = '0;
            frameDone_d = 1'b1;
         end else if (col_q == COL_W'(N2 - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(M - 1)) begin
               row_d      = '0;
               frameErr_d = 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // State register; reset discards any held word and all counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         hold_q      <= '0;
         holdLast_q  <= 1'b0;
         lane_q      <= '0;
         wcnt_q      <= '0;
         row_q       <= '0;
         col_q       <= '0;
         frameDone_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         holdLast_q  <= holdLast_d;
         lane_q      <= lane_d;
         wcnt_q      <= wcnt_d;
         row_q       <= row_d;
         col_q       <= col_d;
         frameDone_q <= frameDone_d;
         frameErr_q  <= frameErr_d;
      end
   end

endmodule

// File: tb/tb_mm_result_unpack.sv
// tb_mm_result_unpack
// Drives packed result words into mm_result_unpack and checks every emitted
// result against a scoreboard of expected values, indices and last flags.
module tb_mm_result_unpack;

   logic        clk;
   logic        rst;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        s_tlast;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic [2:0]  m_row;
   logic [1:0]  m_col;
   logic        frame_done;
   logic        frame_err;

   mm_result_unpack dut (
      .clk        (clk),
      .rst        (rst),
      .s_tdata    (s_tdata),
      .s_tvalid   (s_tvalid),
      .s_tready   (s_tready),
      .s_tlast    (s_tlast),
      .m_tdata    (m_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tlast    (m_tlast),
      .m_row      (m_row),
      .m_col      (m_col),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   typedef struct {
      logic [31:0] data;
      logic [2:0]  row;
      logic [1:0]  col;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        monE;
   int          assertCount = 0;
   int          failCount   = 0;
   logic [2:0]  modelRow;
   logic [1:0]  modelCol;
   logic        doneExp;
   logic        stalled;
   logic [31:0] hData;
   logic [2:0]  hRow;
   logic [1:0]  hCol;
   logic        hLast;
   logic        bubbleCheck;
   int          readyMode;
   int          patIdx;
   logic [3:0]  readyPat;

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges beyond every local bound.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected results of an accepted word, with indices from the bench model.
   task automatic pushWord(input logic [31:0] word, input logic last);
      exp_t        e;
      logic [15:0] v;
      for (int ln = 0; ln < 2; ln++) begin
         v      = word[ln*16 +: 16];
         e.data = {{16{v[15]}}, v};
         e.row  = modelRow;
         e.col  = modelCol;
         e.last = (ln == 1) && last;
         sb.push_back(e);
         if (e.last) begin
            modelRow = 3'd0;
            modelCol = 2'd0;
         end else if (modelCol == 2'd3) begin
            modelCol = 2'd0;
            modelRow = (modelRow == 3'd7) ? 3'd0 : modelRow + 3'd1;
         end else begin
            modelCol = modelCol + 2'd1;
         end
      end
   endtask

   // Offers one word and returns just after the edge that accepted it,
   // leaving s_tvalid high so back-to-back calls stream without gaps.
   task automatic applyStimulus(input logic [31:0] word, input logic last);
      bit got = 0;
      s_tvalid = 1'b1;
      s_tdata  = word;
      s_tlast  = last;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (s_tready) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         checkOutput("s_tready_timeout", 64'd0, 64'd1);
      end else begin
         @(posedge clk);
         #1;
         pushWord(word, last);
      end
   endtask

   task automatic idleInput();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 32'd0;
   endtask

   task automatic waitDrain();
      bit empty = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            empty = 1;
            break;
         end
      end
      if (!empty) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      idleInput();
      sb.delete();
      modelRow = 3'd0;
      modelCol = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Downstream ready: always high, or the repeating 1,0,0,1 pattern.
   initial begin
      m_tready = 1'b1;
      patIdx   = 0;
      forever begin
         @(posedge clk);
         #1;
         if (readyMode == 1) begin
            m_tready = readyPat[patIdx];
            patIdx   = (patIdx + 1) % 4;
         end else begin
            m_tready = 1'b1;
         end
      end
   end

   // Output monitor: scoreboard compare on handshakes, stability under
   // backpressure, frame_done timing and bubble-free streaming.
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
         doneExp = 1'b0;
      end else begin
         checkOutput("frame_done", 64'(frame_done), 64'(doneExp));
         doneExp = 1'b0;
         if (stalled) begin
            checkOutput("stall_valid", 64'(m_tvalid), 64'd1);
            checkOutput("stall_data", 64'(m_tdata), 64'(hData));
            checkOutput("stall_row", 64'(m_row), 64'(hRow));
            checkOutput("stall_col", 64'(m_col), 64'(hCol));
            checkOutput("stall_last", 64'(m_tlast), 64'(hLast));
         end
         if (m_tvalid && !m_tready) begin
            checkOutput("stall_s_tready", 64'(s_tready), 64'd0);
            stalled = 1'b1;
            hData   = m_tdata;
            hRow    = m_row;
            hCol    = m_col;
            hLast   = m_tlast;
         end else begin
            stalled = 1'b0;
         end
         if (bubbleCheck && sb.size() > 0) begin
            checkOutput("no_bubble", 64'(m_tvalid), 64'd1);
         end
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_beat", 64'(m_tdata), 64'hDEAD);
            end else begin
               monE = sb.pop_front();
               checkOutput("m_tdata", 64'(m_tdata), 64'(monE.data));
               checkOutput("m_row", 64'(m_row), 64'(monE.row));
               checkOutput("m_col", 64'(m_col), 64'(monE.col));
               checkOutput("m_tlast", 64'(m_tlast), 64'(monE.last));
               doneExp = monE.last;
            end
         end
      end
   end

   initial begin
      rst         = 1'b1;
      bubbleCheck = 1'b0;
      readyMode   = 0;
      readyPat    = 4'b1001;
      stalled     = 1'b0;
      doneExp     = 1'b0;
      idleInput();

      // Reset state
      doReset();
      @(negedge clk);
      checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("rst_m_tdata", 64'(m_tdata), 64'd0);
      checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
      checkOutput("rst_m_row", 64'(m_row), 64'd0);
      checkOutput("rst_m_col", 64'(m_col), 64'd0);
      checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
      checkOutput("rst_frame_err", 64'(frame_err), 64'd0);
      checkOutput("rst_s_tready", 64'(s_tready), 64'd1);

      // Single word, mixed signs
      @(posedge clk); #1;
      applyStimulus(32'hFFFE_0003, 1'b0);
      idleInput();
      waitDrain();
      checkOutput("single_frame_err", 64'(frame_err), 64'd0);

      // Full frame streamed back to back
      $display("[TB] full frame");
      doReset();
      bubbleCheck = 1'b1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus({16'(2*i + 1), 16'(2*i)}, i == 15);
      end
      idleInput();
      waitDrain();
      bubbleCheck = 1'b0;
      checkOutput("full_frame_err", 64'(frame_err), 64'd0);

      // Backpressure with random data
      $display("[TB] backpressure");
      doReset();
      readyMode = 1;
      for (int i = 0; i < 16; i++) begin
         applyStimulus($urandom, i == 15);
      end
      idleInput();
      waitDrain();
      readyMode = 0;
      checkOutput("bp_frame_err", 64'(frame_err), 64'd0);

      // Early last on word 5
      $display("[TB] early last");
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus({16'(2*i + 1), 16'(2*i)}, i == 5);
      end
      applyStimulus(32'h8000_7FFF, 1'b0);
      idleInput();
      waitDrain();
      checkOutput("early_frame_err", 64'(frame_err), 64'd1);

      // Late last on word 17
      $display("[TB] late last");
      doReset();
      for (int i = 0; i < 17; i++) begin
         applyStimulus({16'(2*i + 1), 16'(2*i)}, i == 16);
         if (i == 14) checkOutput("late_err_before", 64'(frame_err), 64'd0);
         if (i == 15) checkOutput("late_err_at16", 64'(frame_err), 64'd1);
      end
      idleInput();
      waitDrain();
      checkOutput("late_frame_err", 64'(frame_err), 64'd1);

      // Asynchronous reset while holding lane 1
      $display("[TB] async reset");
      doReset();
      applyStimulus(32'h1234_5678, 1'b0);
      idleInput();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("arst_m_tvalid", 64'(m_tvalid), 64'd0);
      checkOutput("arst_m_tdata", 64'(m_tdata), 64'd0);
      checkOutput("arst_m_tlast", 64'(m_tlast), 64'd0);
      checkOutput("arst_m_row", 64'(m_row), 64'd0);
      checkOutput("arst_m_col", 64'(m_col), 64'd0);
      checkOutput("arst_s_tready", 64'(s_tready), 64'd1);
      doReset();
      applyStimulus(32'h0001_FFFF, 1'b0);
      idleInput();
      waitDrain();
      checkOutput("arst_frame_err", 64'(frame_err), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
